// File: rtl/bcd_updown_counter_if.sv
// Control, data and status signals of the BCD up/down counter.
// clk and MR_n stay plain ports on the counter itself.
interface bcd_updown_counter_if #(
    parameter int unsigned DIGITS = 2
);
    localparam int unsigned W = 4 * DIGITS;

    logic         SR_n;
    logic         PE_n;
    logic         CEP;
    logic         CET;
    logic         UP;
    logic [W-1:0] P;
    logic [W-1:0] Q;
    logic         TC;
    logic         ERR;

    modport master (
        output SR_n, PE_n, CEP, CET, UP, P,
        input  Q, TC, ERR
    );

    modport slave (
        input  SR_n, PE_n, CEP, CET, UP, P,
        output Q, TC, ERR
    );
endinterface

// File: rtl/bcd_updown_counter.sv
// Cascadable multi-decade BCD up/down counter with sync clear, parallel load,
// terminal count and a sticky illegal-digit flag.
module bcd_updown_counter #(
    parameter int unsigned DIGITS = 2
) (
    input logic                clk,
    input logic                MR_n,
    bcd_updown_counter_if.slave bus
);
    localparam int unsigned W    = 4 * DIGITS;
    localparam logic [3:0]  NINE = 4'd9;
    localparam logic [3:0]  ZERO = 4'd0;

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic         err_q;
    logic         err_d;

    logic [W-1:0] step_c;
    logic         carry_c;
    logic         any_bad_c;
    logic         all_nine_c;
    logic         all_zero_c;
    logic         step_en_c;
    logic         tc_c;

    // Ripple one carry (up) or borrow (down) through the decades; an illegal
    // digit that is reached snaps to 0/9 and stops the ripple.
    always_comb begin
        step_c     = q_q;
        carry_c    = 1'b1;
        any_bad_c  = 1'b0;
        all_nine_c = 1'b1;
        all_zero_c = 1'b1;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (q_q[4*k +: 4] > NINE) begin
                any_bad_c = 1'b1;
            end
            if (q_q[4*k +: 4] != NINE) begin
                all_nine_c = 1'b0;
            end
            if (q_q[4*k +: 4] != ZERO) begin
                all_zero_c = 1'b0;
            end
            if (carry_c) begin
                if (bus.UP) begin
                    if (q_q[4*k +: 4] > NINE) begin
                        step_c[4*k +: 4] = ZERO;
                        carry_c          = 1'b0;
                    end else if (q_q[4*k +: 4] == NINE) begin
                        step_c[4*k +: 4] = ZERO;
                        carry_c          = 1'b1;
                    end else begin
                        step_c[4*k +: 4] = 4'(q_q[4*k +: 4] + 4'd1);
                        carry_c          = 1'b0;
                    end
                end else begin
                    if (q_q[4*k +: 4] > NINE) begin
                        step_c[4*k +: 4] = NINE;
                        carry_c          = 1'b0;
                    end else if (q_q[4*k +: 4] == ZERO) begin
                        step_c[4*k +: 4] = NINE;
                        carry_c          = 1'b1;
                    end else begin
                        step_c[4*k +: 4] = 4'(q_q[4*k +: 4] - 4'd1);
                        carry_c          = 1'b0;
                    end
                end
            end
        end
    end

    assign step_en_c = bus.CEP & bus.CET;

    // Clear beats load beats count beats hold
    always_comb begin
        q_d   = q_q;
        err_d = err_q;
        if (!bus.SR_n) begin
            q_d   = '0;
            err_d = 1'b0;
        end else if (!bus.PE_n) begin
            q_d = bus.P;
        end else if (step_en_c) begin
            q_d   = step_c;
            err_d = err_q | any_bad_c;
        end
    end

    always_ff @(posedge clk or negedge MR_n) begin
        if (!MR_n) begin
            q_q   <= '0;
            err_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            err_q <= err_d;
        end
    end

    // TC is combinational so a cascade sees the ripple enable in the same cycle
    assign tc_c = bus.CET & (bus.UP ? all_nine_c : all_zero_c);

    assign bus.Q   = q_q;
    assign bus.ERR = err_q;
    assign bus.TC  = tc_c;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed self-checking bench for bcd_updown_counter (DIGITS=2) plus a
// two-instance cascade.
module tb_bcd_updown_counter;
    logic clk;
    logic mr_n;
    int   n_checks;
    int   n_fail;

    bcd_updown_counter_if #(.DIGITS(2)) u_if ();
    bcd_updown_counter_if #(.DIGITS(2)) lo_if ();
    bcd_updown_counter_if #(.DIGITS(2)) hi_if ();

    bcd_updown_counter #(.DIGITS(2)) u_dut (.clk(clk), .MR_n(mr_n), .bus(u_if.slave));
    bcd_updown_counter #(.DIGITS(2)) u_lo  (.clk(clk), .MR_n(mr_n), .bus(lo_if.slave));
    bcd_updown_counter #(.DIGITS(2)) u_hi  (.clk(clk), .MR_n(mr_n), .bus(hi_if.slave));

    // High decade pair shares controls with the low pair; its CET is the low TC
    assign hi_if.SR_n = lo_if.SR_n;
    assign hi_if.PE_n = lo_if.PE_n;
    assign hi_if.CEP  = lo_if.CEP;
    assign hi_if.UP   = lo_if.UP;
    assign hi_if.CET  = lo_if.TC;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] val);
        u_if.PE_n = 1'b0;
        u_if.P    = val;
        tick();
        u_if.PE_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mr_n       = 1'b0;
        u_if.SR_n  = 1'b1;
        u_if.PE_n  = 1'b1;
        u_if.CEP   = 1'b0;
        u_if.CET   = 1'b0;
        u_if.UP    = 1'b1;
        u_if.P     = 8'h00;
        lo_if.SR_n = 1'b1;
        lo_if.PE_n = 1'b1;
        lo_if.CEP  = 1'b0;
        lo_if.CET  = 1'b0;
        lo_if.UP   = 1'b1;
        lo_if.P    = 8'h00;
        hi_if.P    = 8'h00;

        #2;
        check_eq("rst_q", 32'(u_if.Q), 32'h00);
        check_eq("rst_err", 32'(u_if.ERR), 32'h0);
        check_eq("rst_tc_cet0", 32'(u_if.TC), 32'h0);
        #10 mr_n = 1'b1;
        tick();

        // Set ERR, then load 37 and hit MR_n mid-cycle
        load(8'h1C);
        u_if.CEP = 1'b1; u_if.CET = 1'b1; u_if.UP = 1'b1;
        tick();
        u_if.CEP = 1'b0;
        check_eq("ill_up_q", 32'(u_if.Q), 32'h10);
        check_eq("ill_up_err", 32'(u_if.ERR), 32'h1);
        load(8'h37);
        check_eq("load37_q", 32'(u_if.Q), 32'h37);
        check_eq("load_keeps_err", 32'(u_if.ERR), 32'h1);
        #3 mr_n = 1'b0;
        #1;
        check_eq("mr_async_q", 32'(u_if.Q), 32'h00);
        check_eq("mr_async_err", 32'(u_if.ERR), 32'h0);
        u_if.PE_n = 1'b0; u_if.P = 8'h37;
        tick();
        check_eq("mr_hold_vs_load", 32'(u_if.Q), 32'h00);
        #2 mr_n = 1'b1;
        u_if.PE_n = 1'b1;
        tick();
        check_eq("mr_release_hold", 32'(u_if.Q), 32'h00);

        // Up count with wrap
        load(8'h98);
        u_if.UP = 1'b1; u_if.CEP = 1'b1; u_if.CET = 1'b1;
        check_eq("tc_at_98", 32'(u_if.TC), 32'h0);
        tick();
        check_eq("up_99", 32'(u_if.Q), 32'h99);
        check_eq("tc_at_99", 32'(u_if.TC), 32'h1);
        u_if.CEP = 1'b0; #1;
        check_eq("tc_ignores_cep", 32'(u_if.TC), 32'h1);
        u_if.CET = 1'b0; #1;
        check_eq("tc_gated_cet", 32'(u_if.TC), 32'h0);
        u_if.CET = 1'b1; u_if.UP = 1'b0; #1;
        check_eq("tc_dir_down_99", 32'(u_if.TC), 32'h0);
        u_if.UP = 1'b1; u_if.CEP = 1'b1;
        tick();
        check_eq("up_wrap_00", 32'(u_if.Q), 32'h00);
        check_eq("tc_at_00_up", 32'(u_if.TC), 32'h0);
        tick();
        check_eq("up_01", 32'(u_if.Q), 32'h01);
        check_eq("tc_at_01", 32'(u_if.TC), 32'h0);
        u_if.CEP = 1'b0;
        tick();
        check_eq("hold_cep0", 32'(u_if.Q), 32'h01);

        // Down count with borrow and wrap
        load(8'h10);
        u_if.UP = 1'b0; u_if.CEP = 1'b1; u_if.CET = 1'b1;
        tick();
        check_eq("down_09", 32'(u_if.Q), 32'h09);
        tick();
        check_eq("down_08", 32'(u_if.Q), 32'h08);
        u_if.CEP = 1'b0;
        load(8'h00);
        check_eq("tc_at_00_down", 32'(u_if.TC), 32'h1);
        u_if.CEP = 1'b1;
        tick();
        check_eq("down_wrap_99", 32'(u_if.Q), 32'h99);
        check_eq("tc_at_99_down", 32'(u_if.TC), 32'h0);
        u_if.CET = 1'b0;
        tick();
        check_eq("hold_cet0", 32'(u_if.Q), 32'h99);

        // Priority: clear over load over count
        u_if.UP = 1'b1; u_if.CEP = 1'b1; u_if.CET = 1'b1;
        u_if.SR_n = 1'b0; u_if.PE_n = 1'b0; u_if.P = 8'h55;
        tick();
        check_eq("prio_clear", 32'(u_if.Q), 32'h00);
        u_if.SR_n = 1'b1;
        tick();
        check_eq("prio_load", 32'(u_if.Q), 32'h55);
        u_if.PE_n = 1'b1; u_if.CEP = 1'b0;

        // Illegal digits: sticky ERR, clear by SR_n, down-direction snapping
        load(8'h1C);
        check_eq("load_ill_no_err", 32'(u_if.ERR), 32'h0);
        u_if.UP = 1'b1; u_if.CEP = 1'b1;
        tick();
        check_eq("ill_up_q2", 32'(u_if.Q), 32'h10);
        check_eq("ill_up_err2", 32'(u_if.ERR), 32'h1);
        tick();
        check_eq("ill_sticky_q", 32'(u_if.Q), 32'h11);
        check_eq("ill_sticky_err", 32'(u_if.ERR), 32'h1);
        u_if.SR_n = 1'b0;
        tick();
        u_if.SR_n = 1'b1;
        check_eq("sr_clr_q", 32'(u_if.Q), 32'h00);
        check_eq("sr_clr_err", 32'(u_if.ERR), 32'h0);
        u_if.CEP = 1'b0;
        load(8'hA0);
        u_if.UP = 1'b0; u_if.CEP = 1'b1;
        tick();
        check_eq("ill_dn_borrow_q", 32'(u_if.Q), 32'h99);
        check_eq("ill_dn_err", 32'(u_if.ERR), 32'h1);
        u_if.CEP = 1'b0;
        load(8'h5F);
        u_if.CEP = 1'b1;
        tick();
        check_eq("ill_dn_noborrow_q", 32'(u_if.Q), 32'h59);
        u_if.CEP = 1'b0;

        // Cascade 0999 -> 1000
        lo_if.PE_n = 1'b0; lo_if.P = 8'h99; hi_if.P = 8'h09;
        tick();
        lo_if.PE_n = 1'b1;
        lo_if.UP = 1'b1; lo_if.CEP = 1'b1; lo_if.CET = 1'b1;
        #1;
        check_eq("cas_lo_tc", 32'(lo_if.TC), 32'h1);
        tick();
        check_eq("cas_1000", 32'({hi_if.Q, lo_if.Q}), 32'h1000);
        lo_if.CET = 1'b0;
        tick();
        check_eq("cas_hold", 32'({hi_if.Q, lo_if.Q}), 32'h1000);
        check_eq("cas_tc_cet0", 32'(lo_if.TC), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
